// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request port, fixed access latency,
// byte/half/word lanes with load extension, base-address window and error reporting.
module dmem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg;
  logic        we_reg, uns_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg, wdata_reg;

  logic        accept, do_access, wr_en, rd_en, err;
  logic [31:0] offset, wdata_rep, rd_word;
  logic [AW-1:0] word_idx;
  logic [1:0]  lane;
  logic [3:0]  strb;

  logic        rsp_valid_reg, rsp_err_reg, ld_ok_reg, ld_uns_reg;
  logic [1:0]  ld_size_reg, ld_lane_reg;
  logic [31:0] shifted, rdata_ext;

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (cnt_reg == 2'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_req_ready = (state_reg == IDLE);
  end

  assign accept    = i_req_valid && o_req_ready;
  // The access fires on the last BUSY edge; a reset on that same edge drops it.
  assign do_access = (state_reg == BUSY) && (cnt_reg == 2'd0) && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_reg <= 2'd0;
    end else if (accept) begin
      cnt_reg <= 2'(LATENCY - 1);
    end else if (state_reg == BUSY && cnt_reg != 2'd0) begin
      cnt_reg <= cnt_reg - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      we_reg    <= i_req_we;
      addr_reg  <= i_req_addr;
      size_reg  <= i_req_size;
      uns_reg   <= i_req_unsigned;
      wdata_reg <= i_req_wdata;
    end
  end

  always_comb begin
    offset   = addr_reg - BASE_ADDR;
    word_idx = offset[AW+1:2];
    lane     = addr_reg[1:0];
    err      = (size_reg == 2'd3)
            || (size_reg == 2'd1 && addr_reg[0])
            || (size_reg == 2'd2 && addr_reg[1:0] != 2'd0)
            || (addr_reg < BASE_ADDR)
            || ({1'b0, offset} >= WIN_BYTES);
    strb      = 4'b0000;
    wdata_rep = wdata_reg;
    case (size_reg)
      2'd0: begin strb = 4'b0001 << lane; wdata_rep = {4{wdata_reg[7:0]}};  end
      2'd1: begin strb = 4'b0011 << lane; wdata_rep = {2{wdata_reg[15:0]}}; end
      2'd2: strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
  end

  assign wr_en = do_access && we_reg && !err;
  assign rd_en = do_access && !we_reg && !err;

  // One byte-wide RAM per lane so each strobe is a plain write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_reg;
    always_ff @(posedge i_clk) begin
      if (wr_en && strb[gi]) mem[word_idx] <= wdata_rep[gi*8 +: 8];
      if (rd_en)             rd_reg <= mem[word_idx];
    end
    assign rd_word[gi*8 +: 8] = rd_reg;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      ld_ok_reg     <= 1'b0;
      ld_uns_reg    <= 1'b0;
      ld_size_reg   <= 2'd0;
      ld_lane_reg   <= 2'd0;
    end else begin
      rsp_valid_reg <= do_access;
      if (do_access) begin
        rsp_err_reg <= err;
        ld_ok_reg   <= rd_en;
        ld_uns_reg  <= uns_reg;
        ld_size_reg <= size_reg;
        ld_lane_reg <= lane;
      end
    end
  end

  // Lane select and extension sit after the registered RAM read; ld_ok_reg
  // forces zero for stores, errors and after reset.
  always_comb begin
    shifted   = rd_word >> {ld_lane_reg, 3'b000};
    rdata_ext = rd_word;
    case (ld_size_reg)
      2'd0:    rdata_ext = {{24{!ld_uns_reg && shifted[7]}}, shifted[7:0]};
      2'd1:    rdata_ext = {{16{!ld_uns_reg && shifted[15]}}, shifted[15:0]};
      default: rdata_ext = rd_word;
    endcase
    o_rsp_rdata = ld_ok_reg ? rdata_ext : 32'h0;
  end

  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (LATENCY 1/3/4, two base addresses),
// table-driven requests with a response scoreboard plus hand-written timing sequences.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [3];
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_we       [3];
  logic [31:0] req_addr     [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [31:0] req_wdata    [3];
  logic        rsp_valid    [3];
  logic [31:0] rsp_rdata    [3];
  logic        rsp_err      [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    dmem_ctrl #(
      .DEPTH_WORDS(1024),
      .LATENCY    ((gi == 0) ? 1 : ((gi == 1) ? 3 : 4)),
      .BASE_ADDR  ((gi == 1) ? 32'h1000_0000 : 32'h0000_0000)
    ) u_dut (
      .i_clk          (clk),
      .i_reset        (rst[gi]),
      .i_req_valid    (req_valid[gi]),
      .o_req_ready    (req_ready[gi]),
      .i_req_we       (req_we[gi]),
      .i_req_addr     (req_addr[gi]),
      .i_req_size     (req_size[gi]),
      .i_req_unsigned (req_unsigned[gi]),
      .i_req_wdata    (req_wdata[gi]),
      .o_rsp_valid    (rsp_valid[gi]),
      .o_rsp_rdata    (rsp_rdata[gi]),
      .o_rsp_err      (rsp_err[gi])
    );
  end

  typedef struct {
    int          dut;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  exp_t exp_q[$];
  vec_t vecs[$];

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  function automatic vec_t mk(int d, logic we, logic [31:0] addr, logic [1:0] size,
                              logic uns, logic [31:0] wdata, logic [31:0] rdata, logic err);
    vec_t v;
    v.dut = d; v.we = we; v.addr = addr; v.size = size; v.uns = uns;
    v.wdata = wdata; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    req_we[v.dut]       = v.we;
    req_addr[v.dut]     = v.addr;
    req_size[v.dut]     = v.size;
    req_unsigned[v.dut] = v.uns;
    req_wdata[v.dut]    = v.wdata;
  endtask

  task automatic push_exp(vec_t v);
    exp_t e;
    e.dut = v.dut; e.rdata = v.rdata; e.err = v.err;
    exp_q.push_back(e);
  endtask

  // Single request: checks acceptance, BUSY window and response cycle.
  task automatic do_req(vec_t v);
    int d;
    d = v.dut;
    push_exp(v);
    drive(v);
    req_valid[d] = 1'b1;
    check("ready_before_accept", 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    for (int k = 0; k < lat_of(d); k++) begin
      check("busy_ready", 32'(req_ready[d]), 32'd0);
      check("busy_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      @(posedge clk); #1;
    end
    check("rsp_valid_at_latency", 32'(rsp_valid[d]), 32'd1);
    check("ready_with_rsp", 32'(req_ready[d]), 32'd1);
  endtask

  // Scoreboard: every response pulse pops and compares one expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        if (rsp_valid[d] === 1'b1) begin
          $display("[TB] rsp dut%0d rdata=%h err=%b", d, rsp_rdata[d], rsp_err[d]);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: dut%0d got rsp_valid=1 expected none", d);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_dut", 32'(d), 32'(e.dut));
            check("rsp_rdata", rsp_rdata[d], e.rdata);
            check("rsp_err", 32'(rsp_err[d]), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // dut0: LATENCY=1, base 0
    vecs.push_back(mk(0, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 0, 32'h10, 2'd2, 0, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 1, 32'h11, 2'd0, 0, 32'hFFFF_FF80, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h12, 2'd1, 0, 32'hABCD_1234, 32'h0, 0));
    vecs.push_back(mk(0, 0, 32'h10, 2'd2, 0, 32'h0, 32'h123480EF, 0));
    vecs.push_back(mk(0, 0, 32'h11, 2'd0, 0, 32'h0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 0, 32'h11, 2'd0, 1, 32'h0, 32'h00000080, 0));
    vecs.push_back(mk(0, 0, 32'h12, 2'd1, 0, 32'h0, 32'h00001234, 0));
    vecs.push_back(mk(0, 0, 32'h10, 2'd1, 0, 32'h0, 32'hFFFF80EF, 0));
    vecs.push_back(mk(0, 0, 32'h10, 2'd1, 1, 32'h0, 32'h000080EF, 0));
    vecs.push_back(mk(0, 0, 32'h10, 2'd0, 0, 32'h0, 32'hFFFFFFEF, 0));
    vecs.push_back(mk(0, 0, 32'h13, 2'd0, 1, 32'h0, 32'h00000012, 0));
    vecs.push_back(mk(0, 0, 32'h10, 2'd2, 1, 32'h0, 32'h123480EF, 0));
    // dut1: LATENCY=3, base 0x1000_0000, window 4 KiB
    vecs.push_back(mk(1, 1, 32'h1000_0FFC, 2'd2, 0, 32'hCAFEF00D, 32'h0, 0));
    vecs.push_back(mk(1, 1, 32'h1000_0000, 2'd2, 0, 32'h11223344, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h1000_0000, 2'd2, 0, 32'h0, 32'h11223344, 0));
    vecs.push_back(mk(1, 0, 32'h1000_0001, 2'd1, 0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 1, 32'h1000_0002, 2'd2, 0, 32'h5555_5555, 32'h0, 1));
    vecs.push_back(mk(1, 0, 32'h1000_0000, 2'd3, 0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 1, 32'h0FFF_FFFC, 2'd2, 0, 32'h6666_6666, 32'h0, 1));
    vecs.push_back(mk(1, 1, 32'h1000_1000, 2'd2, 0, 32'h7777_7777, 32'h0, 1));
    vecs.push_back(mk(1, 0, 32'h1000_0FFC, 2'd2, 0, 32'h0, 32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 0, 32'h1000_0000, 2'd2, 0, 32'h0, 32'h11223344, 0));
    // dut2: LATENCY=4, prime @0x20 with zero
    vecs.push_back(mk(2, 1, 32'h20, 2'd2, 0, 32'h0, 32'h0, 0));

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_size[d] = 2'd0; req_unsigned[d] = 1'b0; req_wdata[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("reset_ready", 32'(req_ready[d]), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("reset_rdata", rsp_rdata[d], 32'h0);
      check("reset_err", 32'(rsp_err[d]), 32'd0);
      rst[d] = 1'b0;
    end
    mon_en = 1'b1;

    foreach (vecs[i]) do_req(vecs[i]);

    // rdata is held after the pulse
    @(posedge clk); #1;
    check("hold_rsp_valid_low", 32'(rsp_valid[0]), 32'd0);
    check("hold_rdata", rsp_rdata[0], 32'h123480EF);

    // LATENCY=3: second request held valid is accepted only at E4
    v = mk(1, 0, 32'h1000_0000, 2'd2, 0, 32'h0, 32'h11223344, 0);
    push_exp(v);
    drive(v);
    req_valid[1] = 1'b1;
    check("l3_ready_before", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1;
    v = mk(1, 0, 32'h1000_0FFC, 2'd2, 0, 32'h0, 32'hCAFEF00D, 0);
    push_exp(v);
    drive(v);
    for (int k = 0; k < 3; k++) begin
      check("l3_busy_ready", 32'(req_ready[1]), 32'd0);
      check("l3_busy_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      @(posedge clk); #1;
    end
    check("l3_rsp_valid_e3", 32'(rsp_valid[1]), 32'd1);
    check("l3_ready_e3", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("l3_second_accepted_e4", 32'(req_ready[1]), 32'd0);
    check("l3_pulse_one_cycle", 32'(rsp_valid[1]), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("l3_second_busy", 32'(rsp_valid[1]), 32'd0);
    end
    @(posedge clk); #1;
    check("l3_second_rsp_e7", 32'(rsp_valid[1]), 32'd1);
    @(posedge clk); #1;
    check("l3_hold_rdata", rsp_rdata[1], 32'hCAFEF00D);

    // LATENCY=4: reset two cycles after acceptance drops the pending store
    v = mk(2, 1, 32'h20, 2'd2, 0, 32'hAAAA5555, 32'h0, 0);
    drive(v);
    req_valid[2] = 1'b1;
    check("rst_ready_before", 32'(req_ready[2]), 32'd1);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    check("rst_mid_ready", 32'(req_ready[2]), 32'd1);
    check("rst_mid_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    check("rst_mid_rdata", rsp_rdata[2], 32'h0);
    check("rst_mid_err", 32'(rsp_err[2]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("rst_no_rsp", 32'(rsp_valid[2]), 32'd0);
      check("rst_idle_ready", 32'(req_ready[2]), 32'd1);
    end
    do_req(mk(2, 0, 32'h20, 2'd2, 0, 32'h0, 32'h0, 0));

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller placed between the core's load/store port and a word-organised on-chip RAM in the CPU top level. It replaces the single-cycle, word-only data memory with the following features:
- valid/ready request handshake and configurable access latency;
- byte/half/word accesses with byte-lane strobes and load sign/zero extension;
- a base-address window;
- error reporting for misaligned or out-of-window accesses.

It supports one outstanding request at a time.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, at least 4.
- LATENCY, 1: cycles from request acceptance to response; legal range 1..4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be DEPTH_WORDS*4-aligned.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  controller can accept a request.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  32  byte address.
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- i_req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- i_req_wdata  in  32  store data, right-aligned (bits [7:0] for a byte store).
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- o_rsp_err  out  1  access rejected; valid only with o_rsp_valid.

## Operation
State machine: IDLE, BUSY.

IDLE:
- o_req_ready=1.
- On i_req_valid & o_req_ready at an edge: latch we/addr/size/unsigned/wdata, load the counter with LATENCY-1, go to BUSY.

BUSY:
- o_req_ready=0.
- Counter decrements each edge.
- At the edge where the counter is 0: perform the access, register the response, return to IDLE.

Request decode:
- offset = i_req_addr - BASE_ADDR.
- Word index = offset[log2(DEPTH_WORDS)+1:2].
- Lane = addr[1:0].

Error conditions (any one sets err=1):
- size==3;
- half access with addr[0]=1;
- word access with addr[1:0]!=0;
- i_req_addr < BASE_ADDR;
- offset >= DEPTH_WORDS*4.

On error: no RAM write, o_rsp_rdata=0, o_rsp_err=1.

Stores:
- Byte strobes: byte = 4'b0001<<lane; half = 4'b0011<<lane; word = 4'b1111.
- Data is replicated into the lanes (byte: {4{wdata[7:0]}}; half: {2{wdata[15:0]}}).
- Only strobed bytes change.

Loads:
- Read the full word, select the lane.
- Sign- or zero-extend to 32 bits per i_req_unsigned.
- Word loads ignore i_req_unsigned.

RAM contents are not reset and are undefined until written.

## Timing
- Reset values: o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, state IDLE, counter 0.
- Acceptance at edge E0 gives a response registered at edge E(LATENCY):
  - o_rsp_valid=1 for exactly the one cycle following E(LATENCY);
  - o_rsp_rdata and o_rsp_err are held until the next response, and return to 0 only on reset.
- o_req_ready falls after E0 and rises after E(LATENCY), in the same cycle as o_rsp_valid.
  - The next request can therefore be accepted at E(LATENCY+1).
  - Peak throughput is one access per LATENCY+1 cycles.
- Store commit happens at E(LATENCY), not at acceptance. A load accepted at E(LATENCY+1) to the same address returns the new data.
- i_req_* are ignored while o_req_ready=0. The requester must hold i_req_valid until it is accepted; the controller does not require this but only samples in IDLE.
- There is no response back-pressure; the core always consumes o_rsp_valid.
- Reset asserted mid-operation (in BUSY):
  - the pending access is dropped; a pending store is not written;
  - no response is produced;
  - after the reset edge, outputs take their reset values.
- LATENCY=1: BUSY lasts one cycle and the counter is never nonzero.

## Test plan
- LATENCY=1, BASE_ADDR=0: store word 32'hDEADBEEF @0x10 accepted at E0, then load word @0x10. Required: store rsp after E1 with err=0 and rdata=0; load rsp rdata=32'hDEADBEEF; o_req_ready low for exactly one cycle per access.
- Sub-word stores and loads: starting from 32'hDEADBEEF @0x10, store byte 8'h80 @0x11, then store half 16'h1234 @0x12.
  - Load word returns 32'h123480EF.
  - Load byte @0x11 signed returns 32'hFFFFFF80; unsigned returns 32'h00000080.
  - Load half @0x12 signed returns 32'h00001234.
- LATENCY=3: request accepted at E0. Required: o_rsp_valid exactly one cycle after E3; o_req_ready=0 for cycles after E0..E2; a second request held valid is accepted at E4.
- Errors with BASE_ADDR=32'h1000_0000, DEPTH_WORDS=1024:
  - half @0x1000_0001, word @0x1000_0002, size=3, word @0x0FFF_FFFC and word @0x1000_1000 each give err=1, rdata=0;
  - a following load @0x1000_0FFC gives err=0;
  - no memory word changes.
- Reset mid-operation, LATENCY=4: store 32'hAAAA5555 @0x20 over prior 32'h0; assert i_reset two cycles after acceptance. Required: no o_rsp_valid pulse; o_req_ready=1 after the reset edge; a subsequent load @0x20 returns 32'h0.
